pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised N-stage pipeline register chain with a per-stage valid bit, per-stage stall and
//  flush, backward stall propagation with automatic bubble insertion, and halt-sentinel tracking.
//  It generalises the fixed F/D/E/M/W stage registers into one block that the core instantiates
//  between fetch and writeback. The hazard unit drives the StallMask and FlushMask inputs.
// PARAMETERS
//  WIDTH      32            payload bits per stage
//  DEPTH      4             number of stages (>=2); stage 0 is nearest the input
//  BUBBLE     32'hfc000000  payload loaded on a flush or bubble insertion (WIDTH bits)
//  HALT_WORD  32'hffffffff  input payload that marks end of program (WIDTH bits)
// PORTS
//  Clk        in   1            clock; all state changes on posedge
//  Reset      in   1            synchronous, active-high; overrides all other inputs
//  InValid    in   1            InData carries a real entry this cycle
//  InData     in   WIDTH        payload presented to stage 0
//  StallMask  in   DEPTH        bit i=1: stage i holds its contents
//  FlushMask  in   DEPTH        bit i=1: stage i loads a bubble
//  OutValid   out  DEPTH        valid bit of every stage
//  OutData    out  DEPTH*WIDTH  stage i payload on bits [i*WIDTH +: WIDTH]
//  HaltSeen   out  1            sticky; set when HALT_WORD is captured into stage 0
//  Halted     out  1            sticky; set when the halt entry has reached stage DEPTH-1
// BEHAVIOUR
//  - Reset (sync): all OutValid=0, all OutData=BUBBLE, HaltSeen=0, Halted=0, drain counter=0.
//  - Hold_i = OR(StallMask[DEPTH-1:i]). A stall at stage k also freezes every stage below k.
//  - Per-stage priority on each posedge, applied to stage i:
//    1. Reset.
//    2. FlushMask[i]: Valid=0, Data=BUBBLE. Flush takes priority over hold.
//    3. Hold_i: keep contents.
//    4. i>0 and Hold_{i-1}: bubble. The stage directly after a held stage receives a bubble,
//       never a duplicate of the held entry.
//    5. Otherwise: load stage i-1. Stage 0 loads InValid/InData instead.
//  - Latency: an entry accepted at posedge k appears in stage j at posedge k+j when nothing
//    stalls. Every cycle with any stall bit set adds one cycle of latency.
//  - Halt capture: stage 0 loads (rule 5) with InValid=1 and InData==HALT_WORD and HaltSeen=0.
//    On that edge: HaltSeen<=1 and Cnt<=DEPTH-1. Stage 0 still captures the word.
//  - After HaltSeen=1, stage 0 substitutes a bubble for any input under rule 5; InValid is ignored.
//  - Drain counter: Cnt is $clog2(DEPTH) bits, saturating at 0. It decrements on each edge where
//    StallMask==0 and Cnt!=0.
//  - Halted = HaltSeen & (Cnt==0), driven from registers only. It rises in the same cycle the
//    halt word occupies stage DEPTH-1, when no stalls occur.
//  - Flushing the stage that holds the halt word does NOT cancel the halt. Only Reset clears
//    HaltSeen and Halted.
//  - Reset in mid-drain or mid-stall returns every register to its reset value on that edge.
// TESTING
//  1. DEPTH=4. Reset, then push A,B,C,D with InValid=1 on consecutive cycles, no stall/flush.
//     -> A appears in stage 3 on the 4th edge; OutValid=4'b1111.
//  2. Hold StallMask=4'b0010 for 2 cycles while streaming.
//     -> stages 0-1 frozen; stage 2 shows a bubble (Valid=0, Data=fc000000);
//        stage 3 drains normally.
//  3. Assert FlushMask=4'b0001 and StallMask=4'b0001 together.
//     -> stage 0 becomes a bubble (flush wins); stage 1 receives a bubble next edge.
//  4. Push ffffffff.
//     -> HaltSeen=1 on the next cycle; subsequent InValid=1 inputs enter as bubbles;
//        Halted=1 exactly when stage 3 holds ffffffff.
//  5. Halt with one stall cycle injected during the drain.
//     -> Halted is delayed by one cycle. Flushing the stage carrying the halt word
//        -> Halted still asserts.
//  6. Assert Reset during the drain (Cnt=2).
//     -> next cycle all OutValid=0, HaltSeen=0, Halted=0; a new stream is accepted normally.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Handshake/data bundle between the hazard-controlled stage chain and its neighbours.
// The master side drives payload and stall/flush masks; the slave side returns stage state.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  logic                   InValid;
  logic [WIDTH-1:0]       InData;
  logic [DEPTH-1:0]       StallMask;
  logic [DEPTH-1:0]       FlushMask;
  logic [DEPTH-1:0]       OutValid;
  logic [DEPTH*WIDTH-1:0] OutData;
  logic                   HaltSeen;
  logic                   Halted;

  modport master (
    output InValid, InData, StallMask, FlushMask,
    input  OutValid, OutData, HaltSeen, Halted
  );

  modport slave (
    input  InValid, InData, StallMask, FlushMask,
    output OutValid, OutData, HaltSeen, Halted
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// N-stage pipeline register chain with per-stage valid, stall, flush, bubble insertion
// behind held stages, and halt-sentinel drain tracking.
module pipe_stage_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] BUBBLE    = 32'hfc000000,
  parameter logic [WIDTH-1:0] HALT_WORD = 32'hffffffff
) (
  input logic               Clk,
  input logic               Reset,
  pipe_stage_chain_if.slave bus
);

  localparam int           CW       = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [DEPTH-1:0]       stageValidR;
  logic [DEPTH*WIDTH-1:0] stageDataR;
  logic                   haltSeenR;
  logic                   haltedR;
  logic [CW-1:0]          cntR;

  logic [DEPTH-1:0]       holdS;
  logic [DEPTH-1:0]       validNxtS;
  logic [DEPTH*WIDTH-1:0] dataNxtS;
  logic                   captureS;
  logic                   haltSeenNxtS;
  logic [CW-1:0]          cntNxtS;

  // Hold propagates downward: a stall at stage k freezes stages 0..k.
  always_comb begin
    holdS = {DEPTH{1'b0}};
    holdS[DEPTH-1] = bus.StallMask[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      holdS[i] = holdS[i+1] | bus.StallMask[i];
    end
  end

  // Per-stage next state: flush, then hold, then bubble behind a hold, then shift.
  always_comb begin
    validNxtS = stageValidR;
    dataNxtS  = stageDataR;

    if (bus.FlushMask[0]) begin
      validNxtS[0]          = 1'b0;
      dataNxtS[WIDTH-1:0]   = BUBBLE;
    end else if (holdS[0]) begin
      validNxtS[0]          = stageValidR[0];
      dataNxtS[WIDTH-1:0]   = stageDataR[WIDTH-1:0];
    end else if (haltSeenR) begin
      // Nothing past the halt sentinel may enter the chain.
      validNxtS[0]          = 1'b0;
      dataNxtS[WIDTH-1:0]   = BUBBLE;
    end else begin
      validNxtS[0]          = bus.InValid;
      dataNxtS[WIDTH-1:0]   = bus.InData;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (bus.FlushMask[i]) begin
        validNxtS[i]                = 1'b0;
        dataNxtS[i*WIDTH +: WIDTH]  = BUBBLE;
      end else if (holdS[i]) begin
        validNxtS[i]                = stageValidR[i];
        dataNxtS[i*WIDTH +: WIDTH]  = stageDataR[i*WIDTH +: WIDTH];
      end else if (holdS[i-1]) begin
        validNxtS[i]                = 1'b0;
        dataNxtS[i*WIDTH +: WIDTH]  = BUBBLE;
      end else begin
        validNxtS[i]                = stageValidR[i-1];
        dataNxtS[i*WIDTH +: WIDTH]  = stageDataR[(i-1)*WIDTH +: WIDTH];
      end
    end
  end

  // Halt capture and drain countdown; the counter only moves on stall-free edges.
  always_comb begin
    captureS = ~bus.FlushMask[0] & ~holdS[0] & ~haltSeenR & bus.InValid &
               (bus.InData == HALT_WORD);
    haltSeenNxtS = haltSeenR | captureS;
    if (captureS) begin
      cntNxtS = CNT_INIT;
    end else if ((bus.StallMask == {DEPTH{1'b0}}) && (cntR != CNT_ZERO)) begin
      cntNxtS = cntR - CNT_ONE;
    end else begin
      cntNxtS = cntR;
    end
  end

  // State registers; Halted is precomputed from next state so it stays a flop output.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stageValidR <= {DEPTH{1'b0}};
      stageDataR  <= {DEPTH{BUBBLE}};
      haltSeenR   <= 1'b0;
      haltedR     <= 1'b0;
      cntR        <= CNT_ZERO;
    end else begin
      stageValidR <= validNxtS;
      stageDataR  <= dataNxtS;
      haltSeenR   <= haltSeenNxtS;
      haltedR     <= haltSeenNxtS & (cntNxtS == CNT_ZERO);
      cntR        <= cntNxtS;
    end
  end

  assign bus.OutValid = stageValidR;
  assign bus.OutData  = stageDataR;
  assign bus.HaltSeen = haltSeenR;
  assign bus.Halted   = haltedR;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed, table-driven bench for pipe_stage_chain at WIDTH=32, DEPTH=4.
module tb_pipe_stage_chain;

  localparam logic [31:0] BB = 32'hfc000000;
  localparam logic [31:0] HW = 32'hffffffff;

  typedef struct {
    logic        rst;
    logic        inV;
    logic [31:0] inD;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic [3:0]  expV;
    logic [127:0] expD;
    logic        expHs;
    logic        expH;
  } vec_t;

  logic Clk;
  logic Reset;
  int   testsRun;
  int   testsFailed;
  vec_t vecs[16];

  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(4)) bus ();

  pipe_stage_chain #(
    .WIDTH(32), .DEPTH(4), .BUBBLE(32'hfc000000), .HALT_WORD(32'hffffffff)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic rst, input logic inV, input logic [31:0] inD,
                              input logic [3:0] stall, input logic [3:0] flush,
                              input logic [3:0] expV, input logic [31:0] s0,
                              input logic [31:0] s1, input logic [31:0] s2,
                              input logic [31:0] s3, input logic hs, input logic h);
    vec_t v;
    v.rst   = rst;
    v.inV   = inV;
    v.inD   = inD;
    v.stall = stall;
    v.flush = flush;
    v.expV  = expV;
    v.expD  = {s3, s2, s1, s0};
    v.expHs = hs;
    v.expH  = h;
    return v;
  endfunction

  task automatic runVec(input vec_t v, input string name);
    @(negedge Clk);
    Reset         = v.rst;
    bus.InValid   = v.inV;
    bus.InData    = v.inD;
    bus.StallMask = v.stall;
    bus.FlushMask = v.flush;
    @(posedge Clk);
    #1;
    testsRun++;
    if (bus.OutValid !== v.expV) begin
      testsFailed++;
      $display("FAIL %s OutValid: got %b want %b", name, bus.OutValid, v.expV);
    end
    testsRun++;
    if (bus.OutData !== v.expD) begin
      testsFailed++;
      $display("FAIL %s OutData: got %h want %h", name, bus.OutData, v.expD);
    end
    testsRun++;
    if ({bus.HaltSeen, bus.Halted} !== {v.expHs, v.expH}) begin
      testsFailed++;
      $display("FAIL %s HaltSeen/Halted: got %b%b want %b%b", name,
               bus.HaltSeen, bus.Halted, v.expHs, v.expH);
    end
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    Reset         = 1'b1;
    bus.InValid   = 1'b0;
    bus.InData    = 32'h0;
    bus.StallMask = 4'b0000;
    bus.FlushMask = 4'b0000;

    // Reset, streaming, stall bubble, flush-over-stall, halt and drain.
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 4'b0000, BB, BB, BB, BB, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 32'ha,  4'b0000, 4'b0000, 4'b0001, 32'ha, BB, BB, BB, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, 32'hb,  4'b0000, 4'b0000, 4'b0011, 32'hb, 32'ha, BB, BB, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 32'hc,  4'b0000, 4'b0000, 4'b0111, 32'hc, 32'hb, 32'ha, BB, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 32'hd,  4'b0000, 4'b0000, 4'b1111, 32'hd, 32'hc, 32'hb, 32'ha, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 32'he,  4'b0010, 4'b0000, 4'b1011, 32'hd, 32'hc, BB, 32'hb, 1'b0, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 32'he,  4'b0010, 4'b0000, 4'b0011, 32'hd, 32'hc, BB, BB, 1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 32'he,  4'b0000, 4'b0000, 4'b0111, 32'he, 32'hd, 32'hc, BB, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 1'b1, 32'hf,  4'b0001, 4'b0001, 4'b1100, BB, BB, 32'hd, 32'hc, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 32'h10, 4'b0000, 4'b0000, 4'b1001, 32'h10, BB, BB, 32'hd, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 32'h11, 4'b0000, 4'b0000, 4'b0011, 32'h11, 32'h10, BB, BB, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 1'b1, HW,     4'b0000, 4'b0000, 4'b0111, HW, 32'h11, 32'h10, BB, 1'b1, 1'b0);
    vecs[12] = mk(1'b0, 1'b1, 32'h12, 4'b0000, 4'b0000, 4'b1110, BB, HW, 32'h11, 32'h10, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 32'h13, 4'b0000, 4'b0000, 4'b1100, BB, BB, HW, 32'h11, 1'b1, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 32'h14, 4'b0000, 4'b0000, 4'b1000, BB, BB, BB, HW, 1'b1, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,  4'b0000, 4'b0000, 4'b0000, BB, BB, BB, BB, 1'b1, 1'b1);

    for (int i = 0; i < 16; i++) begin
      runVec(vecs[i], $sformatf("vec%0d", i));
    end

    // Halt drain with one stall cycle, then a flush that removes the halt word.
    runVec(mk(1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 4'b0000, BB, BB, BB, BB, 1'b0, 1'b0), "drainRst");
    runVec(mk(1'b0, 1'b1, HW,     4'b0000, 4'b0000, 4'b0001, HW, BB, BB, BB, 1'b1, 1'b0), "drainCap");
    runVec(mk(1'b0, 1'b1, 32'ha,  4'b0000, 4'b0000, 4'b0010, BB, HW, BB, BB, 1'b1, 1'b0), "drain1");
    runVec(mk(1'b0, 1'b1, 32'ha,  4'b1000, 4'b0000, 4'b0010, BB, HW, BB, BB, 1'b1, 1'b0), "drainStall");
    runVec(mk(1'b0, 1'b1, 32'ha,  4'b0000, 4'b0000, 4'b0100, BB, BB, HW, BB, 1'b1, 1'b0), "drainLate");
    runVec(mk(1'b0, 1'b1, 32'ha,  4'b0000, 4'b1000, 4'b0000, BB, BB, BB, BB, 1'b1, 1'b1), "drainFlush");

    // Reset in mid-drain, then a fresh stream is accepted.
    runVec(mk(1'b1, 1'b0, 32'h0,  4'b0000, 4'b0000, 4'b0000, BB, BB, BB, BB, 1'b0, 1'b0), "midRst0");
    runVec(mk(1'b0, 1'b1, HW,     4'b0000, 4'b0000, 4'b0001, HW, BB, BB, BB, 1'b1, 1'b0), "midCap");
    runVec(mk(1'b0, 1'b1, 32'ha,  4'b0000, 4'b0000, 4'b0010, BB, HW, BB, BB, 1'b1, 1'b0), "midCnt2");
    runVec(mk(1'b1, 1'b1, 32'hb,  4'b0011, 4'b0100, 4'b0000, BB, BB, BB, BB, 1'b0, 1'b0), "midRst");
    runVec(mk(1'b0, 1'b1, 32'hc,  4'b0000, 4'b0000, 4'b0001, 32'hc, BB, BB, BB, 1'b0, 1'b0), "newC");
    runVec(mk(1'b0, 1'b1, 32'hd,  4'b0000, 4'b0000, 4'b0011, 32'hd, 32'hc, BB, BB, 1'b0, 1'b0), "newD");
    runVec(mk(1'b0, 1'b0, 32'h0,  4'b0000, 4'b0000, 4'b0110, 32'h0, 32'hd, 32'hc, BB, 1'b0, 1'b0), "newIdle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
